// File: rtl/dcm_rst_seq_if.sv
// dcm_rst_seq_if: control and status bundle of the DCM/PLL reset supervisor.
// The master side drives enables and DCM status; the slave side is the sequencer.
interface dcm_rst_seq_if #(
    parameter int NCH = 3
);
    logic           c_done;
    logic           ovp;
    logic [NCH-1:0] ch_en;
    logic [NCH-1:0] locked;
    logic [NCH-1:0] clkin_stop;
    logic [NCH-1:0] dcm_rst;
    logic [NCH-1:0] fail;
    logic           all_locked;

    modport master (
        output c_done, ovp, ch_en, locked, clkin_stop,
        input  dcm_rst, fail, all_locked
    );

    modport slave (
        input  c_done, ovp, ch_en, locked, clkin_stop,
        output dcm_rst, fail, all_locked
    );
endinterface

// File: rtl/dcm_rst_seq.sv
// dcm_rst_seq: multi-channel DCM/PLL reset pulse, lock timeout and retry supervisor.
// Optional DCM_RST_CASCADE_EN: channel i starts only while the nearest lower enabled channel runs.
module dcm_rst_seq #(
    parameter int NCH        = 3,
    parameter int RST_CYC    = 8,
    parameter int LOCK_TICKS = 4,
    parameter int RETRY_MAX  = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    dcm_rst_seq_if.slave bus
);
    localparam int CW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam int TW = $clog2(LOCK_TICKS + 1);
    localparam int RW = $clog2(RETRY_MAX + 1);

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYC - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(LOCK_TICKS - 1);
    localparam logic [TW-1:0] TICK_SAT  = TW'(LOCK_TICKS);
    localparam logic [RW-1:0] RETRY_TOP = RW'(RETRY_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_WAIT,
        S_RUN,
        S_FAIL
    } state_t;

    state_t        st     [NCH];
    state_t        st_n   [NCH];
    logic [CW-1:0] rc     [NCH];
    logic [CW-1:0] rc_n   [NCH];
    logic [TW-1:0] tk     [NCH];
    logic [TW-1:0] tk_n   [NCH];
    logic [RW-1:0] rt     [NCH];
    logic [RW-1:0] rt_n   [NCH];
    logic [RW-1:0] rt_inc [NCH];

    logic [NCH-1:0] lock_m, lock_s;
    logic [NCH-1:0] stop_m, stop_s;
    logic [NCH-1:0] lost, gate;
    logic [NCH-1:0] run_nx, fail_nx, rst_nx;
    logic           all_nx;
    logic           ovp_d, ovp_tick;

    // Bring asynchronous DCM status into clk and turn ovp into a one-cycle tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_m   <= '0;
            lock_s   <= '0;
            stop_m   <= '0;
            stop_s   <= '0;
            ovp_d    <= 1'b0;
            ovp_tick <= 1'b0;
        end else begin
            lock_m   <= bus.locked;
            lock_s   <= lock_m;
            stop_m   <= bus.clkin_stop;
            stop_s   <= stop_m;
            ovp_d    <= bus.ovp;
            ovp_tick <= bus.ovp & ~ovp_d;
        end
    end

    assign lost = ~lock_s | stop_s;

`ifdef DCM_RST_CASCADE_EN
    // Start gate: the nearest lower enabled channel must be running.
    always_comb begin
        logic g;
        g = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            gate[i] = g;
            if (bus.ch_en[i]) g = (st[i] == S_RUN);
        end
    end
`else
    assign gate = '1;
`endif

    // Per-channel next state and counters; disable and gate-loss override the FSM.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            st_n[i]   = st[i];
            rc_n[i]   = rc[i];
            tk_n[i]   = tk[i];
            rt_n[i]   = rt[i];
            rt_inc[i] = (rt[i] == RETRY_TOP) ? rt[i] : rt[i] + 1'b1;
            if (!bus.c_done || !bus.ch_en[i]) begin
                st_n[i] = S_IDLE;
                rc_n[i] = '0;
                tk_n[i] = '0;
                rt_n[i] = '0;
            end else if (!gate[i] && (st[i] == S_RST ||
                                      st[i] == S_WAIT ||
                                      st[i] == S_RUN)) begin
                st_n[i] = S_IDLE;
                rc_n[i] = '0;
                tk_n[i] = '0;
            end else begin
                unique case (st[i])
                    S_IDLE: begin
                        if (gate[i]) begin
                            st_n[i] = S_RST;
                            rc_n[i] = '0;
                            tk_n[i] = '0;
                        end
                    end
                    S_RST: begin
                        if (rc[i] == RST_LAST) begin
                            st_n[i] = S_WAIT;
                            tk_n[i] = '0;
                        end else begin
                            rc_n[i] = rc[i] + 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (!lost[i]) begin
                            st_n[i] = S_RUN;
                            tk_n[i] = '0;
                        end else if (stop_s[i] ||
                                     (ovp_tick && tk[i] == TICK_LAST)) begin
                            rt_n[i] = rt_inc[i];
                            rc_n[i] = '0;
                            tk_n[i] = '0;
                            st_n[i] = (rt_inc[i] == RETRY_TOP) ? S_FAIL : S_RST;
                        end else if (ovp_tick) begin
                            tk_n[i] = tk[i] + 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (lost[i]) begin
                            rt_n[i] = rt_inc[i];
                            rc_n[i] = '0;
                            tk_n[i] = '0;
                            st_n[i] = (rt_inc[i] == RETRY_TOP) ? S_FAIL : S_RST;
                        end else if (ovp_tick && tk[i] != TICK_SAT) begin
                            tk_n[i] = tk[i] + 1'b1;
                            if (tk[i] == TICK_LAST) rt_n[i] = '0;
                        end
                    end
                    S_FAIL: st_n[i] = S_FAIL;
                    default: st_n[i] = S_IDLE;
                endcase
            end
            run_nx[i]  = (st_n[i] == S_RUN);
            fail_nx[i] = (st_n[i] == S_FAIL);
            rst_nx[i]  = !(st_n[i] == S_WAIT || st_n[i] == S_RUN);
        end
    end

    assign all_nx = (|bus.ch_en) & (&(run_nx | ~bus.ch_en));

    // Channel state and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                st[i] <= S_IDLE;
                rc[i] <= '0;
                tk[i] <= '0;
                rt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                st[i] <= st_n[i];
                rc[i] <= rc_n[i];
                tk[i] <= tk_n[i];
                rt[i] <= rt_n[i];
            end
        end
    end

    // Outputs registered from the next state so lock loss hits dcm_rst in 3 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dcm_rst    <= '1;
            bus.fail       <= '0;
            bus.all_locked <= 1'b0;
        end else begin
            bus.dcm_rst    <= rst_nx;
            bus.fail       <= fail_nx;
            bus.all_locked <= all_nx;
        end
    end
endmodule

// File: tb/tb_dcm_rst_seq.sv
// tb_dcm_rst_seq: directed and randomized checks of dcm_rst_seq against a cycle model.
// A simple DCM model drives locked from dcm_rst with configurable lock delay and glitches.
module tb_dcm_rst_seq;
    localparam int NCH        = 3;
    localparam int RST_CYC    = 8;
    localparam int LOCK_TICKS = 4;
    localparam int RETRY_MAX  = 7;

    localparam int Q_IDLE  = 0;
    localparam int Q_PULSE = 1;
    localparam int Q_SEEK  = 2;
    localparam int Q_HOLD  = 3;
    localparam int Q_FAIL  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    dcm_rst_seq_if #(.NCH(NCH)) bus ();

    dcm_rst_seq #(
        .NCH       (NCH),
        .RST_CYC   (RST_CYC),
        .LOCK_TICKS(LOCK_TICKS),
        .RETRY_MAX (RETRY_MAX)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int ph    [NCH];
    int rleft [NCH];
    int ticks [NCH];
    int tries [NCH];
    bit ls1 [NCH];
    bit ls2 [NCH];
    bit ss1 [NCH];
    bit ss2 [NCH];
    bit ovp_prev, tick_r;
    logic [NCH-1:0] e_rst, e_fail;
    logic           e_all;

    int lk_cnt [NCH];
    int lk_dly [NCH];
    bit dead   [NCH];
    bit rand_dly  = 1'b0;
    int glitch_pm = 0;
    int stop_pm   = 0;
    int ovp_timer = 8;
    logic [NCH-1:0] drop_once, stop_once;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            ph[i] = Q_IDLE; rleft[i] = 0; ticks[i] = 0; tries[i] = 0;
            ls1[i] = 0; ls2[i] = 0; ss1[i] = 0; ss2[i] = 0;
        end
        ovp_prev = 0; tick_r = 0;
        e_rst = '1; e_fail = '0; e_all = 1'b0;
    endtask

    task automatic retry_or_fail(input int i);
        if (tries[i] < RETRY_MAX) tries[i]++;
        if (tries[i] >= RETRY_MAX) ph[i] = Q_FAIL;
        else begin
            ph[i] = Q_PULSE;
            rleft[i] = RST_CYC;
        end
    endtask

    task automatic model_step();
        bit gate [NCH];
        bit lost;
        bit any, allrun;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NCH; i++) gate[i] = 1'b1;
`ifdef DCM_RST_CASCADE_EN
        for (int i = 1; i < NCH; i++)
            for (int j = i - 1; j >= 0; j--)
                if (bus.ch_en[j]) begin
                    gate[i] = (ph[j] == Q_HOLD);
                    break;
                end
`endif
        for (int i = 0; i < NCH; i++) begin
            lost = !ls2[i] || ss2[i];
            if (!bus.c_done || !bus.ch_en[i]) begin
                ph[i] = Q_IDLE; tries[i] = 0; ticks[i] = 0;
            end else if (!gate[i] && (ph[i] == Q_PULSE || ph[i] == Q_SEEK ||
                                      ph[i] == Q_HOLD)) begin
                ph[i] = Q_IDLE; ticks[i] = 0;
            end else begin
                case (ph[i])
                    Q_IDLE: if (gate[i]) begin
                        ph[i] = Q_PULSE; rleft[i] = RST_CYC; ticks[i] = 0;
                    end
                    Q_PULSE: begin
                        rleft[i]--;
                        if (rleft[i] == 0) begin ph[i] = Q_SEEK; ticks[i] = 0; end
                    end
                    Q_SEEK: begin
                        if (!lost) begin
                            ph[i] = Q_HOLD; ticks[i] = 0;
                        end else if (ss2[i] || (tick_r && ticks[i] + 1 >= LOCK_TICKS)) begin
                            retry_or_fail(i);
                        end else if (tick_r) ticks[i]++;
                    end
                    Q_HOLD: begin
                        if (lost) retry_or_fail(i);
                        else if (tick_r) begin
                            ticks[i]++;
                            if (ticks[i] == LOCK_TICKS) tries[i] = 0;
                        end
                    end
                    default: ;
                endcase
            end
        end
        for (int i = 0; i < NCH; i++) begin
            ls2[i] = ls1[i]; ls1[i] = bus.locked[i];
            ss2[i] = ss1[i]; ss1[i] = bus.clkin_stop[i];
        end
        tick_r = bus.ovp && !ovp_prev;
        ovp_prev = bus.ovp;
        any = 0; allrun = 1;
        for (int i = 0; i < NCH; i++) begin
            e_rst[i]  = (ph[i] != Q_SEEK && ph[i] != Q_HOLD);
            e_fail[i] = (ph[i] == Q_FAIL);
            if (bus.ch_en[i]) begin
                any = 1;
                if (ph[i] != Q_HOLD) allrun = 0;
            end
        end
        e_all = any && allrun;
    endtask

    task automatic env_drive();
        for (int i = 0; i < NCH; i++) begin
            if (bus.dcm_rst[i]) begin
                lk_cnt[i] = 0;
                if (rand_dly) lk_dly[i] = $urandom_range(3, 70);
            end else lk_cnt[i]++;
            bus.locked[i] = !dead[i] && lk_cnt[i] >= lk_dly[i] && !drop_once[i]
                            && ($urandom_range(0, 999) >= glitch_pm);
            bus.clkin_stop[i] = stop_once[i] || ($urandom_range(0, 999) < stop_pm);
        end
        drop_once = '0;
        stop_once = '0;
        ovp_timer--;
        if (ovp_timer <= 0) begin
            bus.ovp = 1'b1;
            ovp_timer = $urandom_range(6, 14);
        end else bus.ovp = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("dcm_rst", 32'(bus.dcm_rst), 32'(e_rst));
        check("fail", 32'(bus.fail), 32'(e_fail));
        check("all_locked", 32'(bus.all_locked), 32'(e_all));
        env_drive();
    endtask

    initial begin
        int n, falls, lock_at;
        bit prev;
        bus.c_done = 1'b0; bus.ovp = 1'b0; bus.ch_en = '0;
        bus.locked = '0; bus.clkin_stop = '0;
        drop_once = '0; stop_once = '0;
        for (int i = 0; i < NCH; i++) begin
            lk_cnt[i] = 0; lk_dly[i] = 20; dead[i] = 0;
        end
        model_reset();

        repeat (3) cyc();
        check("reset_dcm_rst", 32'(bus.dcm_rst), 32'({NCH{1'b1}}));
        check("reset_fail", 32'(bus.fail), 32'd0);
        check("reset_all_locked", 32'(bus.all_locked), 32'd0);

        rst_n = 1'b1; bus.c_done = 1'b1; bus.ch_en = '1;
        n = 0;
        do begin cyc(); n++; end while (bus.dcm_rst[0] && n < 40);
        check("first_fall_cycles", n, RST_CYC + 1);
        lock_at = -1; n = 0;
        while (!bus.all_locked && n < 100) begin
            cyc(); n++;
            if (lock_at < 0 && bus.locked == '1) lock_at = n;
        end
        check("all_locked_latency", n - lock_at, 3);

        drop_once[0] = 1'b1;
        cyc();
        n = 0;
        do begin cyc(); n++; end while (!bus.dcm_rst[0] && n < 20);
        check("loss_latency", n, 3);
        n = 0;
        while (bus.dcm_rst[0] && n < 40) begin cyc(); n++; end
        check("loss_pulse_len", n, RST_CYC);

        n = 0;
        while (!bus.all_locked && n < 200) begin cyc(); n++; end
        check("relock", 32'(bus.all_locked), 32'd1);
        stop_once[2] = 1'b1;
        cyc();
        n = 0;
        do begin cyc(); n++; end while (bus.all_locked && n < 10);
        check("stop_drop_latency", n, 3);
        check("stop_rst2", 32'(bus.dcm_rst[2]), 32'd1);
        repeat (100) cyc();

        bus.c_done = 1'b0;
        cyc();
        dead[1] = 1'b1; bus.c_done = 1'b1;
        falls = 0; n = 0; prev = bus.dcm_rst[1];
        while (!bus.fail[1] && n < 3000) begin
            cyc(); n++;
            if (prev && !bus.dcm_rst[1]) falls++;
            prev = bus.dcm_rst[1];
        end
        check("timeout_pulses", falls, RETRY_MAX);
        repeat (60) cyc();
        check("fail_sticky", 32'(bus.fail), 32'(3'b010));
        check("fail_rst_held", 32'(bus.dcm_rst[1]), 32'd1);
`ifndef DCM_RST_CASCADE_EN
        check("others_running", 32'({bus.dcm_rst[2], bus.dcm_rst[0]}), 32'd0);
`endif

        bus.c_done = 1'b0;
        cyc();
        check("ovr_fail", 32'(bus.fail), 32'd0);
        check("ovr_rst", 32'(bus.dcm_rst), 32'({NCH{1'b1}}));
        check("ovr_all", 32'(bus.all_locked), 32'd0);
        dead[1] = 1'b0; bus.c_done = 1'b1;
        n = 0;
        while (!bus.all_locked && n < 300) begin cyc(); n++; end
        check("restart_locked", 32'(bus.all_locked), 32'd1);

        rand_dly = 1'b1; glitch_pm = 3; stop_pm = 2;
        for (int k = 0; k < 4000; k++) begin
            cyc();
            if ($urandom_range(0, 59) == 0)
                bus.ch_en = NCH'($urandom_range(0, (1 << NCH) - 1));
            if (bus.c_done && $urandom_range(0, 299) == 0) bus.c_done = 1'b0;
            else if (!bus.c_done && $urandom_range(0, 4) == 0) bus.c_done = 1'b1;
        end

        glitch_pm = 0; stop_pm = 0; bus.c_done = 1'b1; bus.ch_en = '1;
        n = 0;
        while (!bus.all_locked && n < 2000) begin cyc(); n++; end
        drop_once[0] = 1'b1;
        n = 0;
        do begin cyc(); n++; end while (!bus.dcm_rst[0] && n < 20);
        repeat (2) cyc();
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_dcm_rst", 32'(bus.dcm_rst), 32'({NCH{1'b1}}));
        check("async_rst_all", 32'(bus.all_locked), 32'd0);
        repeat (3) cyc();
        rst_n = 1'b1;
        repeat (300) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
